ekf_innovation: RTL and testbench
=================================

# ekf_innovation

Measurement-innovation stage of the EKF, directly downstream of the prediction stage. When the prediction stage finishes, this block reads the predicted state, the predicted covariance and the current position measurement from shared memory. It computes the innovation y = z − H·x_pred and the innovation covariance S = H·P·Hᵀ + R, with H = [I₂ 0] (position-only sensor). It also computes det(S) for the Kalman-gain stage that follows. All arithmetic is Q16.16 signed with saturation.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; fixed Q16.16 (16 fraction bits)
- ADDR_WIDTH, 8, memory address width
- X_BASE, 0, predicted state x_pred[0..3]
- P_BASE, 4, predicted covariance P, 4×4 row-major (P[i][j] at P_BASE+4i+j)
- Z_BASE, 20, measurement z[0..1]
- R_BASE, 22, measurement noise R, 2×2 row-major
- Y_BASE, 26, output y[0..1]
- S_BASE, 28, output S, 2×2 row-major
- DET_BASE, 32, output det(S)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one run; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of run
- singular  out  1  det(S)==0 on last run; valid from done, held until next start
- sat  out  1  any saturation occurred on last run; valid from done, held until next start
- mem_addr_rd  out  ADDR_WIDTH  read address
- mem_data_rd  in  DATA_WIDTH  read data, one-cycle latency
- mem_addr_wr  out  ADDR_WIDTH  write address
- mem_data_wr  out  DATA_WIDTH  write data
- mem_we  out  1  write strobe

## Operation
- FSM states: IDLE → READ → COMPUTE → DET → WRITE → DONE → IDLE.
- **IDLE:** start=1 moves the FSM to READ; this clears singular, sat and the counter.
- **READ:** issues 12 addresses, counter k=0..11, in this order:
  - X_BASE+0, X_BASE+1
  - P_BASE+0, P_BASE+1, P_BASE+4, P_BASE+5
  - Z_BASE+0, Z_BASE+1
  - R_BASE+0..3
  - Data for address k is captured one cycle later. READ lasts 13 cycles; the last cycle is capture only.
- **COMPUTE** (1 cycle):
  - y_i = sat(z_i − x_i)
  - S_ij = sat(P_ij + R_ij), i,j ∈ {0,1}
  - 33-bit intermediates, clamp to 0x7FFF_FFFF / 0x8000_0000.
- **DET** (1 cycle):
  - det = sat((S00·S11 − S01·S10) >>> 16)
  - Full 64-bit signed products, 65-bit difference, arithmetic right shift (floor), no intermediate saturation.
  - singular = (det==0).
- **WRITE:** 7 cycles, mem_we=1, counter w=0..6, in order y0, y1, S00, S01, S10, S11, det, to Y_BASE+0..1, S_BASE+0..3, DET_BASE.
- **DONE:** done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- sat is set if any clamp fires in COMPUTE or DET.
- start while not in IDLE is ignored (no queuing).
- mem_we is never high outside WRITE. mem_addr_rd is don't-care outside READ but is driven (holds last value).

## Timing
- Reset values: busy=0, done=0, singular=0, sat=0, mem_we=0, mem_addr_rd=0, mem_addr_wr=0, mem_data_wr=0. FSM goes to IDLE.
- Timeline, with start accepted at edge T0:
  - T0+1..T0+12: read addresses
  - T0+2..T0+13: captures
  - T0+14: COMPUTE
  - T0+15: DET
  - T0+16..T0+22: writes
  - T0+23: done
  - start→done latency: 23 cycles. Earliest next accepted start: T0+24.
- All outputs are registered. mem_we, mem_addr_wr and mem_data_wr change together on the same edge.
- Reset asserted mid-run: all outputs return to reset values immediately (async). No further writes and no done. Memory contents already written stay as they are.
- start held high continuously: a new run begins at T0+24 (back-to-back).

## Test plan
- **Nominal:**
  - Stimulus: x=[1.0, 2.0, *, *] (0x0001_0000, 0x0002_0000); P00=P11=0.5, P01=P10=0; R00=R11=0.25, R01=R10=0; z=[1.5, 1.0].
  - Expected writes: y=[0x0000_8000, 0xFFFF_0000], S=[0x0000_C000, 0, 0, 0x0000_C000], det=0x0000_9000.
  - Expected status: done at T0+23; singular=0, sat=0.
- **Singular:** P top-left all 1.0, R=0 → S all 0x0001_0000, det=0, singular=1, sat=0.
- **Innovation saturation:** z0=0x7FFF_0000, x0=0x8000_0000 → y0=0x7FFF_FFFF, sat=1; other outputs correct.
- **Det saturation:** S00=S11=256.0 (0x0100_0000), off-diagonals 0 → det=0x7FFF_FFFF, sat=1, singular=0.
- **Reset mid-write:** rst_n low at T0+18 → mem_we=0 the same cycle, no done. A rerun of the nominal case then gives the exact nominal results.
- **Busy protocol:** start pulses at T0+5 and T0+20 are ignored (one done only, at T0+23). start held high gives done at T0+23 and T0+47; the memory read pattern is identical on both runs.

Source files
------------

// File: rtl/ekf_innovation.sv
// EKF measurement-innovation stage: reads x_pred, P, z, R from shared memory and
// writes y = z - H*x, S = H*P*H' + R and det(S), all Q16.16 with saturation.
module ekf_innovation #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int X_BASE     = 0,
    parameter int P_BASE     = 4,
    parameter int Z_BASE     = 20,
    parameter int R_BASE     = 22,
    parameter int Y_BASE     = 26,
    parameter int S_BASE     = 28,
    parameter int DET_BASE   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  singular,
    output logic                  sat,
    output logic [ADDR_WIDTH-1:0] mem_addr_rd,
    input  logic [DATA_WIDTH-1:0] mem_data_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr_wr,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    output logic                  mem_we
);

    localparam int DW   = DATA_WIDTH;
    localparam int W1   = DW + 1;
    localparam int W2   = 2 * DW;
    localparam int W3   = 2 * DW + 1;
    localparam int FRAC = 16;

    localparam logic [DW-1:0] MAX_W = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MIN_W = {1'b1, {(DW-1){1'b0}}};
    localparam logic [3:0]    RD_LAST = 4'd12;
    localparam logic [3:0]    WR_LAST = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_COMPUTE,
        S_DET,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [3:0]            cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  singular_q, singular_d;
    logic                  sat_q, sat_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_wr_q, addr_wr_d;
    logic [DW-1:0]         data_wr_q, data_wr_d;

    // Captured operands in read order: x0 x1 P00 P01 P10 P11 z0 z1 R00 R01 R10 R11
    logic signed [DW-1:0] rd_q [12];
    // Results in write order: y0 y1 S00 S01 S10 S11 det
    logic signed [DW-1:0] res_q [7];

    function automatic logic [ADDR_WIDTH-1:0] rd_addr(input logic [3:0] k);
        int a;
        case (k)
            4'd0:    a = X_BASE;
            4'd1:    a = X_BASE + 1;
            4'd2:    a = P_BASE;
            4'd3:    a = P_BASE + 1;
            4'd4:    a = P_BASE + 4;
            4'd5:    a = P_BASE + 5;
            4'd6:    a = Z_BASE;
            4'd7:    a = Z_BASE + 1;
            4'd8:    a = R_BASE;
            4'd9:    a = R_BASE + 1;
            4'd10:   a = R_BASE + 2;
            default: a = R_BASE + 3;
        endcase
        return ADDR_WIDTH'(a);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] wr_addr(input logic [3:0] k);
        int a;
        case (k)
            4'd0:    a = Y_BASE;
            4'd1:    a = Y_BASE + 1;
            4'd2:    a = S_BASE;
            4'd3:    a = S_BASE + 1;
            4'd4:    a = S_BASE + 2;
            4'd5:    a = S_BASE + 3;
            default: a = DET_BASE;
        endcase
        return ADDR_WIDTH'(a);
    endfunction

    function automatic logic signed [W1-1:0] sx1(input logic signed [DW-1:0] a);
        return {a[DW-1], a};
    endfunction

    function automatic logic signed [W2-1:0] sx2(input logic signed [DW-1:0] a);
        return {{DW{a[DW-1]}}, a};
    endfunction

    function automatic logic signed [W3-1:0] sx3(input logic signed [W2-1:0] a);
        return {a[W2-1], a};
    endfunction

    // Returns {clamped, value}
    function automatic logic [DW:0] clamp_sum(input logic signed [W1-1:0] v);
        if (v > $signed({1'b0, MAX_W})) return {1'b1, MAX_W};
        if (v < $signed({1'b1, MIN_W})) return {1'b1, MIN_W};
        return {1'b0, v[DW-1:0]};
    endfunction

    function automatic logic [DW:0] clamp_det(input logic signed [W3-1:0] v);
        if (v > $signed({{(DW+1){1'b0}}, MAX_W})) return {1'b1, MAX_W};
        if (v < $signed({{(DW+1){1'b1}}, MIN_W})) return {1'b1, MIN_W};
        return {1'b0, v[DW-1:0]};
    endfunction

    logic [DW:0]          y0_c, y1_c, s00_c, s01_c, s10_c, s11_c, det_c;
    logic signed [W2-1:0] prod_a, prod_b;
    logic signed [W3-1:0] diff_c, shifted_c;
    logic                 sum_clamp_c;

    always_comb begin
        y0_c  = clamp_sum(sx1(rd_q[6]) - sx1(rd_q[0]));
        y1_c  = clamp_sum(sx1(rd_q[7]) - sx1(rd_q[1]));
        s00_c = clamp_sum(sx1(rd_q[2]) + sx1(rd_q[8]));
        s01_c = clamp_sum(sx1(rd_q[3]) + sx1(rd_q[9]));
        s10_c = clamp_sum(sx1(rd_q[4]) + sx1(rd_q[10]));
        s11_c = clamp_sum(sx1(rd_q[5]) + sx1(rd_q[11]));
        sum_clamp_c = y0_c[DW] | y1_c[DW] | s00_c[DW] | s01_c[DW] | s10_c[DW] | s11_c[DW];
    end

    // Determinant is exact up to the final shift; only the result is clamped
    always_comb begin
        prod_a    = sx2(res_q[2]) * sx2(res_q[5]);
        prod_b    = sx2(res_q[3]) * sx2(res_q[4]);
        diff_c    = sx3(prod_a) - sx3(prod_b);
        shifted_c = diff_c >>> FRAC;
        det_c     = clamp_det(shifted_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_READ;
            S_READ:    if (cnt_q == RD_LAST) state_d = S_COMPUTE;
            S_COMPUTE: state_d = S_DET;
            S_DET:     state_d = S_WRITE;
            S_WRITE:   if (cnt_q == WR_LAST) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        singular_d = singular_q;
        sat_d      = sat_q;
        we_d       = 1'b0;
        addr_rd_d  = addr_rd_q;
        addr_wr_d  = addr_wr_q;
        data_wr_d  = data_wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    singular_d = 1'b0;
                    sat_d      = 1'b0;
                end
            end
            S_READ: begin
                if (cnt_q < RD_LAST) addr_rd_d = rd_addr(cnt_q);
                cnt_d = cnt_q + 4'd1;
            end
            S_COMPUTE: begin
                sat_d = sat_q | sum_clamp_c;
            end
            S_DET: begin
                sat_d      = sat_q | det_c[DW];
                singular_d = (det_c[DW-1:0] == '0);
                cnt_d      = '0;
            end
            S_WRITE: begin
                we_d      = 1'b1;
                addr_wr_d = wr_addr(cnt_q);
                for (int i = 0; i < 7; i++) begin
                    if (cnt_q == 4'(i)) data_wr_d = res_q[i];
                end
                cnt_d = cnt_q + 4'd1;
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            singular_q <= 1'b0;
            sat_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_rd_q  <= '0;
            addr_wr_q  <= '0;
            data_wr_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            singular_q <= singular_d;
            sat_q      <= sat_d;
            we_q       <= we_d;
            addr_rd_q  <= addr_rd_d;
            addr_wr_q  <= addr_wr_d;
            data_wr_q  <= data_wr_d;
        end
    end

    // Read data lags its address by one cycle, so count k captures operand k-1
    always_ff @(posedge clk) begin
        if (state_q == S_READ) begin
            for (int i = 0; i < 12; i++) begin
                if (cnt_q == 4'(i + 1)) rd_q[i] <= mem_data_rd;
            end
        end
        if (state_q == S_COMPUTE) begin
            res_q[0] <= y0_c[DW-1:0];
            res_q[1] <= y1_c[DW-1:0];
            res_q[2] <= s00_c[DW-1:0];
            res_q[3] <= s01_c[DW-1:0];
            res_q[4] <= s10_c[DW-1:0];
            res_q[5] <= s11_c[DW-1:0];
        end
        if (state_q == S_DET) res_q[6] <= det_c[DW-1:0];
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign singular    = singular_q;
    assign sat         = sat_q;
    assign mem_we      = we_q;
    assign mem_addr_rd = addr_rd_q;
    assign mem_addr_wr = addr_wr_q;
    assign mem_data_wr = data_wr_q;

endmodule

// File: tb/tb_ekf_innovation.sv
// Scoreboard bench for ekf_innovation: random and directed runs against a wide-integer
// reference of the innovation, innovation covariance and determinant.
module tb_ekf_innovation;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int XB = 0;
    localparam int PB = 4;
    localparam int ZB = 20;
    localparam int RB = 22;
    localparam int YB = 26;
    localparam int SB = 28;
    localparam int DB = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, singular, sat, mem_we;
    logic [AW-1:0] mem_addr_rd, mem_addr_wr;
    logic [DW-1:0] mem_data_rd, mem_data_wr;

    logic [DW-1:0] inm  [256];
    logic [DW-1:0] outm [256];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t        wq [$];
    logic [1:0] sq [$];

    logic [DW-1:0] stim  [12];
    logic [DW-1:0] exp_w [7];
    logic [1:0]    exp_status;

    int rd_ref [12] = '{XB, XB+1, PB, PB+1, PB+4, PB+5, ZB, ZB+1, RB, RB+1, RB+2, RB+3};
    int wr_ref [7]  = '{YB, YB+1, SB, SB+1, SB+2, SB+3, DB};

    int checks   = 0;
    int failures = 0;

    ekf_innovation #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .X_BASE(XB), .P_BASE(PB), .Z_BASE(ZB),
        .R_BASE(RB), .Y_BASE(YB), .S_BASE(SB), .DET_BASE(DB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .singular(singular),
        .sat(sat),
        .mem_addr_rd(mem_addr_rd),
        .mem_data_rd(mem_data_rd),
        .mem_addr_wr(mem_addr_wr),
        .mem_data_wr(mem_data_wr),
        .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    assign mem_data_rd = inm[mem_addr_rd];

    always @(posedge clk) begin
        if (mem_we) outm[mem_addr_wr] <= mem_data_wr;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: signed arithmetic on 128-bit integers, clamp to the 32-bit range
    function automatic logic signed [127:0] sx(input logic [31:0] a);
        return {{96{a[31]}}, a};
    endfunction

    function automatic logic [32:0] clampq(input logic signed [127:0] v);
        if (v > 128'sh7FFF_FFFF)  return {1'b1, 32'h7FFF_FFFF};
        if (v < -128'sh8000_0000) return {1'b1, 32'h8000_0000};
        return {1'b0, v[31:0]};
    endfunction

    task automatic model();
        logic [32:0]            r [7];
        logic signed [127:0]    d;
        logic                   any_sat;
        r[0] = clampq(sx(stim[6]) - sx(stim[0]));
        r[1] = clampq(sx(stim[7]) - sx(stim[1]));
        r[2] = clampq(sx(stim[2]) + sx(stim[8]));
        r[3] = clampq(sx(stim[3]) + sx(stim[9]));
        r[4] = clampq(sx(stim[4]) + sx(stim[10]));
        r[5] = clampq(sx(stim[5]) + sx(stim[11]));
        d = (sx(r[2][31:0]) * sx(r[5][31:0]) - sx(r[3][31:0]) * sx(r[4][31:0])) >>> 16;
        r[6] = clampq(d);
        any_sat = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_w[i] = r[i][31:0];
            any_sat  = any_sat | r[i][32];
        end
        exp_status = {r[6][31:0] == 32'h0, any_sat};
    endtask

    task automatic push_all();
        for (int i = 0; i < 7; i++) wq.push_back('{a: AW'(wr_ref[i]), d: exp_w[i]});
        sq.push_back(exp_status);
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) inm[i] = $urandom;
        for (int k = 0; k < 12; k++) inm[rd_ref[k]] = stim[k];
    endtask

    function automatic logic [31:0] rnd();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
    endfunction

    task automatic set_nominal();
        stim = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0, 32'h0, 32'h0000_8000,
                 32'h0001_8000, 32'h0001_0000, 32'h0000_4000, 32'h0, 32'h0, 32'h0000_4000};
    endtask

    // Called just after a negedge; start is sampled at the next posedge (T0)
    task automatic launch(input bit hold, input int pa, input int pb);
        load_mem();
        model();
        push_all();
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 23; c++) begin
            start = hold | (c == pa) | (c == pb);
            @(negedge clk);
            if (c <= 12) chk($sformatf("rd_addr[%0d]", c - 1), 64'(mem_addr_rd), 64'(rd_ref[c-1]));
            chk($sformatf("we@T0+%0d", c),   64'(mem_we), 64'(c >= 16 && c <= 22));
            chk($sformatf("busy@T0+%0d", c), 64'(busy),   64'(c <= 22));
            chk($sformatf("done@T0+%0d", c), 64'(done),   64'(c == 23));
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic check_nominal_mem();
        chk("nom_y0",  64'(outm[YB]),   64'h0000_8000);
        chk("nom_y1",  64'(outm[YB+1]), 64'hFFFF_0000);
        chk("nom_s00", 64'(outm[SB]),   64'h0000_C000);
        chk("nom_s01", 64'(outm[SB+1]), 64'h0);
        chk("nom_s10", 64'(outm[SB+2]), 64'h0);
        chk("nom_s11", 64'(outm[SB+3]), 64'h0000_C000);
        chk("nom_det", 64'(outm[DB]),   64'h0000_9000);
        chk("nom_status", 64'({singular, sat}), 64'h0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_t e;
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %h data %h with none pending", mem_addr_wr, mem_data_wr);
                end else begin
                    e = wq.pop_front();
                    chk("write", 64'({mem_addr_wr, mem_data_wr}), 64'({e.a, e.d}));
                end
            end
            if (done) begin
                logic [1:0] s;
                if (sq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: singular %b sat %b with none pending", singular, sat);
                end else begin
                    s = sq.pop_front();
                    chk("status{singular,sat}", 64'({singular, sat}), 64'(s));
                end
            end
        end
    end

    initial begin
        set_nominal();
        for (int i = 0; i < 256; i++) outm[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, singular, sat, mem_we}), 64'h0);
        chk("reset_bus",  64'({mem_addr_rd, mem_addr_wr, mem_data_wr}), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        set_nominal();
        launch(1'b0, 0, 0);
        check_nominal_mem();

        set_nominal();
        stim[2] = 32'h0001_0000; stim[3] = 32'h0001_0000;
        stim[4] = 32'h0001_0000; stim[5] = 32'h0001_0000;
        for (int i = 8; i < 12; i++) stim[i] = 32'h0;
        launch(1'b0, 0, 0);
        chk("sing_status", 64'({singular, sat}), 64'h2);
        chk("sing_s01", 64'(outm[SB+1]), 64'h0001_0000);
        chk("sing_det", 64'(outm[DB]), 64'h0);

        set_nominal();
        stim[6] = 32'h7FFF_0000;
        stim[0] = 32'h8000_0000;
        launch(1'b0, 0, 0);
        chk("insat_y0", 64'(outm[YB]), 64'h7FFF_FFFF);
        chk("insat_sat", 64'(sat), 64'h1);
        chk("insat_det", 64'(outm[DB]), 64'h0000_9000);

        set_nominal();
        stim[2] = 32'h0100_0000; stim[5] = 32'h0100_0000;
        for (int i = 8; i < 12; i++) stim[i] = 32'h0;
        launch(1'b0, 0, 0);
        chk("detsat_det", 64'(outm[DB]), 64'h7FFF_FFFF);
        chk("detsat_status", 64'({singular, sat}), 64'h1);

        set_nominal();
        launch(1'b0, 5, 20);
        check_nominal_mem();

        set_nominal();
        launch(1'b1, 0, 0);
        launch(1'b0, 0, 0);
        check_nominal_mem();

        // Reset during the write phase: only y0 and y1 may reach memory
        set_nominal();
        load_mem();
        model();
        wq.push_back('{a: AW'(YB),     d: exp_w[0]});
        wq.push_back('{a: AW'(YB + 1), d: exp_w[1]});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 64'(mem_we), 64'h0);
        chk("rst_mid_ctrl", 64'({busy, done, singular, sat}), 64'h0);
        chk("rst_mid_bus", 64'({mem_addr_rd, mem_addr_wr, mem_data_wr}), 64'h0);
        chk("rst_mid_writes_seen", 64'(wq.size()), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("rst_no_done[%0d]", c), 64'({done, mem_we, busy}), 64'h0);
        end

        set_nominal();
        launch(1'b0, 0, 0);
        check_nominal_mem();

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 12; i++) stim[i] = rnd();
            launch(1'b0, 0, 0);
        end

        repeat (5) @(negedge clk);
        chk("writes_drained", 64'(wq.size()), 64'h0);
        chk("status_drained", 64'(sq.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
